aes_keyadd_stream: RTL
======================

# aes_keyadd_stream

Streaming, word-serial AES AddRoundKey stage: XORs a 128-bit state with a 128-bit round subkey delivered as `128/WORD_W` beats, with valid/ready handshakes on both sides and one registered output stage. It is the parametrised successor of the combinational key-addition layer. It sits between the round datapath and the key schedule in narrow-bus AES configurations (8/32/64-bit), and in 128-bit mode when the key addition must be registered. It also tracks block framing, supports a per-beat bypass mode, and flags framing errors.

## Interface
- `WORD_W`, 32, beat width in bits; legal values 8, 16, 32, 64, 128. Other values must fail elaboration.
- `NWORDS`, 128/WORD_W, derived local parameter: beats per block.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `clear`  in  1  synchronous flush of the output stage, beat counter and error flag.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`.
- `in_state`  in  WORD_W  state word. Beat 0 carries state bits [127:128-WORD_W], MSB first.
- `in_key`  in  WORD_W  subkey word, same bit ordering as `in_state`.
- `in_bypass`  in  1  per beat: 1 = pass `in_state` unmodified, 0 = XOR with `in_key`.
- `in_last`  in  1  producer marks the final beat of a block.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`.
- `out_data`  out  WORD_W  registered result word.
- `out_last`  out  1  final beat of the block, generated from the internal counter.
- `err`  out  1  sticky framing-error flag.

## Operation
- Datapath per accepted beat: `out_data <= in_bypass ? in_state : in_state ^ in_key`.
- Output register is a single stage.
  - `in_ready = !out_valid || out_ready` (combinational). This gives full throughput: one beat per cycle under continuous ready.
  - On accept, the register loads and `out_valid` goes 1.
  - On output handshake with no new accept, `out_valid` goes 0.
  - While `out_valid && !out_ready`, `out_data`, `out_last` and `out_valid` hold stable.
- Beat counter `cnt`, width `clog2(NWORDS)` (minimum 1 bit), counts accepted input beats.
  - `out_last <= (cnt == NWORDS-1)` on accept.
  - `cnt` wraps to 0 after `NWORDS-1`.
  - `cnt` also forces to 0 on any accepted `in_last`, for resynchronisation.
- Framing check on each accepted beat: `err <= 1` if `in_last != (cnt == NWORDS-1)`. `err` stays set until `rst` or `clear`.
- `WORD_W = 128`: `NWORDS = 1`, `cnt` is constant 0, and every beat has `out_last = 1`.
- `clear` has priority over a simultaneous input accept.
  - It sets `out_valid`, `cnt` and `err` to 0.
  - The beat offered in the same cycle is dropped. `in_ready` is still computed normally, so the producer must not rely on acceptance during `clear`.
- No internal state depends on key contents. Subkey words are not stored beyond the output register.

## Timing
- Reset values: `out_valid = 0`, `out_data = 0`, `out_last = 0`, `err = 0`, `cnt = 0`. `in_ready = 1` immediately after reset.
- Latency: 1 cycle from input accept to `out_valid`/`out_data`.
- Throughput: 1 beat/cycle; one block per `NWORDS` cycles.
- Backpressure: `out_ready = 0` with `out_valid = 1` drops `in_ready` in the same cycle. There is no combinational path from `in_valid` to `out_valid`.
- Simultaneous output handshake and input accept: the register reloads, `out_valid` stays 1, with no bubble.
- `rst` asserted mid-block discards the partial block. After reset the next accepted beat is beat 0.
- `err` updates in the cycle after the offending accept, together with that beat's `out_valid`.

## Test plan
- **Plain XOR, 32-bit words, ready held high.**
  - Stimulus: 4 beats of FIPS-197 round-0 state `3243f6a8 885a308d 313198a2 e0370734` with key `2b7e1516 28aed2a6 abf71588 09cf4f3c`, `in_last` on beat 3.
  - Required: `out_data` = `193de3be a0f4e22b 9ac68d2a e9f84808` on 4 consecutive cycles, 1 cycle after each input; `out_last` only on the 4th beat; `err = 0`.
- **Backpressure.**
  - Stimulus: same block with `out_ready` toggling 1,0,0,1,...
  - Required: `in_ready` low whenever `out_valid && !out_ready`; `out_data` stable while stalled; no beat lost or duplicated.
- **Bypass.**
  - Stimulus: `in_bypass = 1` on beats 1 and 3 of the block above.
  - Required: output `193de3be 885a308d 9ac68d2a e0370734`.
- **Framing error.**
  - Stimulus: `in_last` on beat 1 of a 4-beat block.
  - Required: `err = 1` from the next cycle; the following beat is counted as beat 0, and `out_last` is next set 3 beats later.
  - Then pulse `clear`: `err = 0`, `out_valid = 0`.
- **Parameter sweep.**
  - Stimulus: `WORD_W` = 8 and 128, same FIPS vector.
  - Required: 16 beats with `out_last` on beat 15 (WORD_W = 8); 1 beat with `out_last = 1` (WORD_W = 128); identical 128-bit result.
- **Reset mid-block.**
  - Stimulus: assert `rst` after beat 2 while `out_valid = 1`.
  - Required: all outputs at reset values asynchronously; the next block is framed from beat 0 with `err = 0`.

Source files
------------

// File: rtl/aes_keyadd_stream.sv
// Word-serial AES AddRoundKey stage: XORs state beats with subkey beats behind a
// single registered valid/ready output stage, with block framing and a sticky error flag.
module aes_keyadd_stream #(
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_state,
   input  logic [WORD_W-1:0] in_key,
   input  logic              in_bypass,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic              out_last,
   output logic              err
);

   localparam int NWORDS = 128 / WORD_W;
   localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(NWORDS - 1);

   if (!(WORD_W == 8 || WORD_W == 16 || WORD_W == 32 || WORD_W == 64 || WORD_W == 128)) begin : g_bad_width
      $error("aes_keyadd_stream: WORD_W must be 8, 16, 32, 64 or 128");
   end

   logic [CW-1:0] cnt;
   logic          accept;
   logic          at_last;

   always_comb begin
      in_ready = !out_valid || out_ready;
      accept   = in_valid && in_ready;
      at_last  = (cnt == LAST_CNT);
   end

   // clear outranks a same-cycle accept; the offered beat is simply dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         err       <= 1'b0;
         cnt       <= '0;
      end else if (clear) begin
         out_valid <= 1'b0;
         err       <= 1'b0;
         cnt       <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= in_bypass ? in_state : (in_state ^ in_key);
         out_last  <= at_last;
         cnt       <= (in_last || at_last) ? '0 : cnt + CW'(1);
         if (in_last != at_last) err <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
